// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared word width and loader state encoding.
package imem_loader_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } load_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles a big-endian 32-bit word from an accepted byte stream.
// word/word_valid present the completed word combinationally on the 4th accepted byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [7:0]        in_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  // Byte counter and shift register; only the three oldest bytes need storing
  // because the fourth is taken straight from in_data when the word completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= {shreg[15:0], in_data};
    end
  end

  assign word       = {shreg, in_data};
  assign word_valid = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader. Takes a header word N followed
// by N big-endian instruction words and writes them from BASE_ADDR upward, holding
// the CPU in reset until the load completes.
// Optional: define LOADER_CHECKSUM_EN to require a trailing mod-2^32 sum word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [WORD_W-1:0] MAX_N = WORD_W'(1) << ADDR_W;

  load_state_t       state, state_next;
  logic [ADDR_W:0]   n_q;
  logic              accept;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;
`endif

  assign in_ready  = (state == HDR) || (state == DATA) || (state == CSUM);
  assign mem_we    = (state == WRITE);
  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign accept    = in_valid && in_ready;
  assign last_word = ((words_loaded + (ADDR_W+1)'(1)) == n_q);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .in_data    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HDR;
    else       state <= state_next;
  end

  // Next-state logic; DONE and ERR are left only through reset
  always_comb begin
    state_next = state;
    case (state)
      HDR: if (word_valid) begin
        if (word == '0) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end else if (word > MAX_N) begin
          state_next = ERR;
        end else begin
          state_next = DATA;
        end
      end
      DATA:  if (word_valid) state_next = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (word_valid) state_next = (word == sum_q) ? DONE : ERR;
`endif
      DONE:    state_next = DONE;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  // Word count, write address/data, checksum and registered CPU reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q          <= '0;
      mem_addr     <= BASE;
      mem_wdata    <= '0;
      words_loaded <= '0;
      cpu_reset    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      // N never exceeds 2**ADDR_W once accepted, so ADDR_W+1 bits hold it exactly
      if (state == HDR && word_valid) n_q <= word[ADDR_W:0];
      if (state == DATA && word_valid) begin
        mem_wdata <= word;
`ifdef LOADER_CHECKSUM_EN
        sum_q     <= sum_q + word;
`endif
      end
      if (state == WRITE) begin
        mem_addr     <= mem_addr + ADDR_W'(1);
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
      end
      cpu_reset <= (state_next != DONE);
    end
  end

endmodule
